// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority, and
// multicycle results are queued in a FIFO that a starvation stall guarantees to drain.
module regfile_wr_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mc_valid,
  output logic                     mc_ready,
  input  logic [ADDR_W-1:0]        mc_rd,
  input  logic [DATA_W-1:0]        mc_data,
  output logic                     WE3,
  output logic [ADDR_W-1:0]        AD3,
  output logic [DATA_W-1:0]        WD3,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   mc_count,
  output logic                     proto_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [ADDR_W-1:0] r_mem_rd   [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [WAIT_W-1:0] r_starve;
  logic              r_stall;
  logic              r_proto_err;

  logic              w_wb_hit;
  logic              w_nonempty;
  logic              w_pop;
  logic              w_push;
  logic [WAIT_W-1:0] w_starve_nxt;

  assign w_wb_hit   = wb_we && (wb_rd != '0);
  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty && !w_wb_hit;
  // Ready is a pure function of occupancy, so a same-cycle pop never frees a slot early.
  assign mc_ready   = (r_count < CNT_W'(DEPTH));
  // rd=0 results complete the handshake but are never stored.
  assign w_push     = mc_valid && mc_ready && (mc_rd != '0);

  assign stall_o   = r_stall;
  assign mc_count  = r_count;
  assign proto_err = r_proto_err;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    WE3 = 1'b0;
    AD3 = '0;
    WD3 = '0;
    if (w_wb_hit) begin
      WE3 = 1'b1;
      AD3 = wb_rd;
      WD3 = wb_data;
    end else if (w_nonempty) begin
      WE3 = 1'b1;
      AD3 = r_mem_rd[r_head];
      WD3 = r_mem_data[r_head];
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || !w_nonempty)
      w_starve_nxt = '0;
    else if (w_wb_hit && (r_starve != WAIT_W'(MAX_WAIT)))
      w_starve_nxt = r_starve + 1'b1;
  end

  // NOTE: the storage array has no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_tail]   <= mc_rd;
      r_mem_data[r_tail] <= mc_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      r_stall     <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_starve <= w_starve_nxt;
      if (w_pop)
        r_stall <= 1'b0;
      else if (w_starve_nxt == WAIT_W'(MAX_WAIT))
        r_stall <= 1'b1;
      if (w_wb_hit && r_stall)
        r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: a per-cycle vector table for basic
// muxing and FIFO flow, plus hand sequences for full, starvation, violation and reset.
module tb_regfile_wr_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              mc_valid;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_rd;
  logic [DATA_W-1:0] mc_data;
  logic              WE3;
  logic [ADDR_W-1:0] AD3;
  logic [DATA_W-1:0] WD3;
  logic              stall_o;
  logic [2:0]        mc_count;
  logic              proto_err;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_wr_arbiter #(.DEPTH(4), .MAX_WAIT(8), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .WE3(WE3), .AD3(AD3), .WD3(WD3),
    .stall_o(stall_o), .mc_count(mc_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        exp_we3;
    logic [4:0]  exp_ad3;
    logic [31:0] exp_wd3;
    logic [2:0]  exp_count;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    wb_we = we; wb_rd = rd; wb_data = d;
    mc_valid = mv; mc_rd = mrd; mc_data = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic port(input string name, input logic we, input logic [4:0] ad, input logic [31:0] wd);
    check({name, "_we3"}, 64'(WE3), 64'(we));
    check({name, "_ad3"}, 64'(AD3), 64'(ad));
    check({name, "_wd3"}, 64'(WD3), 64'(wd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                wb_we rd  data          mv  mrd mdata  we3 ad3 wd3           cnt rdy
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 3'd0, 1'b1};
    vecs[2]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h1,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'h2,  1'b1, 5'd10, 32'h1,        3'd1, 1'b1};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 5'd11, 32'h2,        3'd1, 1'b1};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55, 1'b0, 5'd0,  32'h0,        3'd0, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1};
    vecs[9]  = '{1'b1, 5'd0,  32'hAA,       1'b1, 5'd12, 32'h3,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1};
    vecs[10] = '{1'b1, 5'd0,  32'hBB,       1'b0, 5'd0,  32'h0,  1'b1, 5'd12, 32'h3,        3'd1, 1'b1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,        3'd0, 1'b1};

    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("in_reset_count", 64'(mc_count), 64'd0);
    rst = 1'b1;
    #1;
    port("reset", 1'b0, 5'd0, 32'h0);
    check("reset_ready", 64'(mc_ready), 64'd1);
    check("reset_stall", 64'(stall_o), 64'd0);
    check("reset_proto", 64'(proto_err), 64'd0);
    tick();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_data,
            vecs[i].mc_valid, vecs[i].mc_rd, vecs[i].mc_data);
      #1;
      port($sformatf("vec%0d", i), vecs[i].exp_we3, vecs[i].exp_ad3, vecs[i].exp_wd3);
      check($sformatf("vec%0d_count", i), 64'(mc_count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d_ready", i), 64'(mc_ready), 64'(vecs[i].exp_ready));
      tick();
    end

    // Fill while WB owns the port every cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd3, 32'hA0 + i, 1'b1, 5'(20 + i), 32'(100 + i));
      #1;
      port($sformatf("fill%0d", i), 1'b1, 5'd3, 32'hA0 + i);
      check($sformatf("fill%0d_count", i), 64'(mc_count), 64'(i));
      tick();
    end
    drive(1'b1, 5'd3, 32'hA4, 1'b1, 5'd24, 32'd104);
    #1;
    check("full_count", 64'(mc_count), 64'd4);
    check("full_ready", 64'(mc_ready), 64'd0);
    tick();
    check("held_count", 64'(mc_count), 64'd4);
    check("held_ready", 64'(mc_ready), 64'd0);
    wb_we = 1'b0;
    #1;
    port("drain0", 1'b1, 5'd20, 32'd100);
    check("drain0_ready", 64'(mc_ready), 64'd0);
    tick();
    port("drain1", 1'b1, 5'd21, 32'd101);
    check("drain1_ready", 64'(mc_ready), 64'd1);
    check("drain1_count", 64'(mc_count), 64'd3);
    tick();
    mc_valid = 1'b0;
    #1;
    check("drain2_count", 64'(mc_count), 64'd3);
    port("drain2", 1'b1, 5'd22, 32'd102);
    tick();
    port("drain3", 1'b1, 5'd23, 32'd103);
    tick();
    port("drain4", 1'b1, 5'd24, 32'd104);
    tick();
    port("drained", 1'b0, 5'd0, 32'h0);
    check("drained_count", 64'(mc_count), 64'd0);

    // Starvation: one queued entry, WB hits for MAX_WAIT cycles.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    tick();
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("starve%0d_stall", k), 64'(stall_o), 64'd0);
      check($sformatf("starve%0d_ad3", k), 64'(AD3), 64'd4);
      tick();
    end
    check("stall_set", 64'(stall_o), 64'd1);
    check("stall_count", 64'(mc_count), 64'd1);

    drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
    #1;
    port("viol", 1'b1, 5'd7, 32'h77);
    check("viol_proto_pre", 64'(proto_err), 64'd0);
    tick();
    check("viol_proto", 64'(proto_err), 64'd1);
    check("viol_stall", 64'(stall_o), 64'd1);
    wb_we = 1'b0;
    #1;
    port("stall_head", 1'b1, 5'd9, 32'h99);
    tick();
    check("unstall", 64'(stall_o), 64'd0);
    check("unstall_count", 64'(mc_count), 64'd0);
    check("proto_sticky", 64'(proto_err), 64'd1);
    tick();
    check("proto_sticky2", 64'(proto_err), 64'd1);

    // Reset mid-fill discards queued entries.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd3, 32'h0, 1'b1, 5'(13 + i), 32'(200 + i));
      tick();
    end
    check("prefill_count", 64'(mc_count), 64'd3);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("async_count", 64'(mc_count), 64'd0);
    check("async_proto", 64'(proto_err), 64'd0);
    check("async_we3", 64'(WE3), 64'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("post_rst%0d_we3", i), 64'(WE3), 64'd0);
      check($sformatf("post_rst%0d_count", i), 64'(mc_count), 64'd0);
      check($sformatf("post_rst%0d_ready", i), 64'(mc_ready), 64'd1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (WE3/AD3/WD3) between two requesters.
- Pipeline writeback (WB) has fixed priority and zero latency, with no backpressure.
- The multicycle unit (MC, e.g. divider or slow load) uses valid/ready and is buffered in a small FIFO.
- A starvation counter raises a stall to the pipeline so buffered MC results always drain.

Parameters:
- DEPTH, 4: MC FIFO entries (power of two, ≥2).
- MAX_WAIT, 8: consecutive blocked cycles before stall_o asserts (≥1).
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_we  in  1  WB write request, this cycle.
- wb_rd  in  ADDR_W  WB destination register.
- wb_data  in  DATA_W  WB write data.
- mc_valid  in  1  MC result offered.
- mc_ready  out  1  FIFO can accept.
- mc_rd  in  ADDR_W  MC destination register.
- mc_data  in  DATA_W  MC result data.
- WE3  out  1  register-file write enable.
- AD3  out  ADDR_W  register-file write address.
- WD3  out  DATA_W  register-file write data.
- stall_o  out  1  pipeline must keep wb_we low while high.
- mc_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- proto_err  out  1  sticky: WB wrote while stall_o was high.

Behaviour:
- Reset (rst low, async): FIFO empty, mc_count=0, starve counter=0, stall_o=0, proto_err=0. mc_ready=1 immediately after release. Reset mid-operation discards all buffered MC entries; no write is issued for them.
- wb_hit = wb_we && wb_rd!=0. WB requests with rd=0 are ignored; they do not block MC.
- Write-port mux (combinational, same cycle):
  - If wb_hit: WE3=1, AD3=wb_rd, WD3=wb_data.
  - Else if FIFO non-empty: WE3=1, AD3/WD3 = FIFO head; pop at the clock edge.
  - Else: WE3=0, AD3=0, WD3=0.
- MC handshake:
  - Transfer occurs when mc_valid && mc_ready at a rising edge.
  - mc_ready = (mc_count < DEPTH). It depends on state only; a same-cycle pop gives no credit.
  - mc_rd=0 transfers are accepted but not enqueued.
  - The MC side must hold mc_rd/mc_data stable while mc_valid && !mc_ready.
- Latency: an MC entry accepted at edge N is written no earlier than the cycle after N. There is no combinational MC→WE3 path.
- Order: MC entries are written strictly in FIFO order.
- WAW ordering between WB and MC to the same register is the hazard unit's responsibility. This block does not reorder or drop.
- Simultaneous push and pop in one cycle: mc_count is unchanged, and the head and tail pointers both advance with wrap-around modulo DEPTH.
- Starvation counter:
  - Increments when the FIFO is non-empty && wb_hit, saturating at MAX_WAIT.
  - Clears on any pop or when the FIFO is empty.
- stall_o is registered:
  - Set at the edge where the counter reaches MAX_WAIT.
  - Cleared at the edge following the first pop.
  - Pipeline contract: while stall_o=1, wb_we must be 0, so the head is written in that cycle.
- Protocol violation: if wb_hit && stall_o, WB still wins the port, proto_err sets at the next edge, and it stays set until reset.
- mc_count is registered and equals the number of entries in the FIFO.

Test Plan:
- Reset release → WE3=0, mc_ready=1, mc_count=0, stall_o=0. Assert rst low mid-fill with 3 entries → mc_count=0 asynchronously, and no further writes occur.
- WB only: wb_we=1, rd=5, data=0xDEADBEEF → same cycle WE3=1, AD3=5, WD3=0xDEADBEEF. With wb_rd=0 → WE3=0.
- MC only: push rd=10/0x1, then rd=11/0x2 on consecutive edges, with WB idle → writes (10,0x1) then (11,0x2) on the next two cycles. mc_count goes 1,1,0, because push and pop coincide in the middle cycle.
- Full: WB busy every cycle (wb_rd=3), push 4 MC results → mc_count=4, mc_ready=0. A 5th mc_valid is held; after a pop, mc_ready=1 and it is accepted.
- Starvation: FIFO holds 1 entry, wb_hit held 8 cycles → stall_o=1 after the 8th edge. Drop wb_we → head written that cycle, and stall_o=0 the next cycle.
- Violation: keep wb_we=1, rd=7 while stall_o=1 → WB still written to x7, and proto_err=1 at the next edge and remains 1.
